// File: rtl/f_d_test_d.sv
// Expectation FIFO: registered pointers with an extra wrap bit to tell full from empty.
// Latency: 1 cycle push to visible head. Backpressure: o_push_rdy = !full, judged at start of cycle;
// a same-cycle pop does not free a slot for a push, and a push into an empty FIFO is not poppable that cycle.
module f_d_test_d_fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push_vld,
    output logic               o_push_rdy,
    input  logic [p_width-1:0] i_push_dat,
    output logic               o_pop_vld,
    input  logic               i_pop_rdy,
    output logic [p_width-1:0] o_pop_dat
);
    localparam int AW = $clog2(p_depth);

    logic [AW:0]        r_wr;
    logic [AW:0]        r_rd;
    logic [p_width-1:0] r_mem [p_depth];
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    assign w_empty    = (r_wr == r_rd);
    assign w_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_push     = i_push_vld & ~w_full;
    assign w_pop      = i_pop_rdy & ~w_empty;
    assign o_push_rdy = ~w_full;
    assign o_pop_vld  = ~w_empty;
    assign o_pop_dat  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_push_dat;
    end
endmodule

// Decode-side sink for the fetch->decode interface: checks each accepted (pc, inst) against preloaded expectations.
// Latency: check result/counters visible 1 cycle after fire; squash asserts the cycle after the firing cycle.
// Backpressure: rdy only in RECV; low for 1 squash cycle and p_recv_intv_delay cycles after each fire.
module f_d_test_d #(
    parameter int p_addr_bits       = 32,
    parameter int p_inst_bits       = 32,
    parameter int p_recv_intv_delay = 0,
    parameter int p_num_exp         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   val,
    output logic                   rdy,
    input  logic [p_addr_bits-1:0] pc,
    input  logic [p_inst_bits-1:0] inst,
    output logic                   squash,
    output logic [p_addr_bits-1:0] branch_target,
    input  logic                   exp_val,
    output logic                   exp_rdy,
    input  logic [p_addr_bits-1:0] exp_pc,
    input  logic [p_inst_bits-1:0] exp_inst,
    input  logic                   exp_squash,
    input  logic [p_addr_bits-1:0] exp_target,
    output logic                   done,
    output logic                   error,
    output logic [15:0]            err_count,
    output logic [15:0]            recv_count
);
    typedef struct packed {
        logic                   sq;
        logic [p_addr_bits-1:0] tgt;
        logic [p_inst_bits-1:0] inst;
        logic [p_addr_bits-1:0] pc;
    } exp_t;

    localparam int EW   = $bits(exp_t);
    localparam int CW   = (p_recv_intv_delay > 1) ? $clog2(p_recv_intv_delay + 1) : 1;
    localparam logic [CW-1:0] DLY = CW'(p_recv_intv_delay);

    typedef enum logic [1:0] {S_RECV, S_DELAY, S_SQUASH} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [p_addr_bits-1:0] r_target;
    logic             r_error;
    logic [15:0]      r_err_count;
    logic [15:0]      r_recv_count;

    exp_t             w_push_dat;
    logic [EW-1:0]    w_head_dat;
    exp_t             w_head;
    logic             w_nonempty;
    logic             w_fire;
    logic             w_pop;
    logic             w_ok;
    logic             w_fail;

    assign w_push_dat = '{sq: exp_squash, tgt: exp_target, inst: exp_inst, pc: exp_pc};
    assign w_head     = exp_t'(w_head_dat);

    f_d_test_d_fifo #(
        .p_width (EW),
        .p_depth (p_num_exp)
    ) u_exp_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (exp_val),
        .o_push_rdy (exp_rdy),
        .i_push_dat (w_push_dat),
        .o_pop_vld  (w_nonempty),
        .i_pop_rdy  (w_pop),
        .o_pop_dat  (w_head_dat)
    );

    assign rdy           = (r_state == S_RECV);
    assign squash        = (r_state == S_SQUASH);
    assign branch_target = r_target;
    assign done          = ~w_nonempty & (r_state == S_RECV);
    assign error         = r_error;
    assign err_count     = r_err_count;
    assign recv_count    = r_recv_count;

    assign w_fire = val & rdy & ~squash;
    assign w_pop  = w_fire & w_nonempty;
    assign w_ok   = (pc == w_head.pc) && (inst == w_head.inst);

    // Pass is the only explicit branch so an unknown compare falls into the failure path.
    always_comb begin
        w_fail = 1'b0;
        if (w_fire) begin
            if (w_nonempty && w_ok) w_fail = 1'b0;
            else                    w_fail = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RECV: begin
                if (w_pop && w_head.sq) begin
                    w_state_nxt = S_SQUASH;
                end else if (w_fire && (p_recv_intv_delay > 0)) begin
                    w_state_nxt = S_DELAY;
                    w_cnt_nxt   = DLY;
                end
            end
            S_DELAY: begin
                if (r_cnt == CW'(1)) w_state_nxt = S_RECV;
                else                 w_cnt_nxt   = r_cnt - CW'(1);
            end
            S_SQUASH: begin
                if (p_recv_intv_delay > 0) begin
                    w_state_nxt = S_DELAY;
                    w_cnt_nxt   = DLY;
                end else begin
                    w_state_nxt = S_RECV;
                end
            end
            default: w_state_nxt = S_RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RECV;
            r_cnt        <= '0;
            r_target     <= '0;
            r_error      <= 1'b0;
            r_err_count  <= '0;
            r_recv_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_pop && w_head.sq) r_target <= w_head.tgt;
            if (w_fire) r_recv_count <= r_recv_count + 16'd1;
            if (w_fail) begin
                r_error <= 1'b1;
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_f_d_test_d.sv
// Randomized bench for the fetch->decode sink: two instances (delay 0/depth 16, delay 2/depth 4)
// driven in turn; a transaction-level model predicts each cycle's outputs into a scoreboard queue.
module tb_f_d_test_d;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        val [2];
    logic        rdy [2];
    logic        squash [2];
    logic        exp_val [2];
    logic        exp_rdy [2];
    logic        exp_squash [2];
    logic        done [2];
    logic        error [2];
    logic [31:0] pc [2];
    logic [31:0] inst [2];
    logic [31:0] bt [2];
    logic [31:0] exp_pc [2];
    logic [31:0] exp_inst [2];
    logic [31:0] exp_target [2];
    logic [15:0] errc [2];
    logic [15:0] recvc [2];

    f_d_test_d #(.p_addr_bits(32), .p_inst_bits(32), .p_recv_intv_delay(0), .p_num_exp(16)) u0 (
        .clk(clk), .rst(rst[0]), .val(val[0]), .rdy(rdy[0]), .pc(pc[0]), .inst(inst[0]),
        .squash(squash[0]), .branch_target(bt[0]), .exp_val(exp_val[0]), .exp_rdy(exp_rdy[0]),
        .exp_pc(exp_pc[0]), .exp_inst(exp_inst[0]), .exp_squash(exp_squash[0]),
        .exp_target(exp_target[0]), .done(done[0]), .error(error[0]),
        .err_count(errc[0]), .recv_count(recvc[0]));

    f_d_test_d #(.p_addr_bits(32), .p_inst_bits(32), .p_recv_intv_delay(2), .p_num_exp(4)) u1 (
        .clk(clk), .rst(rst[1]), .val(val[1]), .rdy(rdy[1]), .pc(pc[1]), .inst(inst[1]),
        .squash(squash[1]), .branch_target(bt[1]), .exp_val(exp_val[1]), .exp_rdy(exp_rdy[1]),
        .exp_pc(exp_pc[1]), .exp_inst(exp_inst[1]), .exp_squash(exp_squash[1]),
        .exp_target(exp_target[1]), .done(done[1]), .error(error[1]),
        .err_count(errc[1]), .recv_count(recvc[1]));

    typedef struct {
        int          k;
        logic        rdy, sq, erdy, done, err, chk_bt;
        logic [15:0] errc, recvc;
        logic [31:0] bt;
    } rec_t;

    typedef struct {
        logic [31:0] pc, inst, tgt;
        logic        sq;
    } ent_t;

    rec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %h want %h", nm, k, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            chk("rdy",        r.k, 32'(rdy[r.k]),     32'(r.rdy));
            chk("squash",     r.k, 32'(squash[r.k]),  32'(r.sq));
            chk("exp_rdy",    r.k, 32'(exp_rdy[r.k]), 32'(r.erdy));
            chk("done",       r.k, 32'(done[r.k]),    32'(r.done));
            chk("error",      r.k, 32'(error[r.k]),   32'(r.err));
            chk("err_count",  r.k, 32'(errc[r.k]),    32'(r.errc));
            chk("recv_count", r.k, 32'(recvc[r.k]),   32'(r.recvc));
            if (r.chk_bt) chk("branch_target", r.k, bt[r.k], r.bt);
        end
    end

    // Model: a queue of expectations; after each fire rdy drops for one squash cycle (if requested) plus D cycles.
    task automatic run(input int k, input int ncyc);
        int          dly     = (k == 0) ? 0 : 2;
        int          depth   = (k == 0) ? 16 : 4;
        ent_t        q[$];
        bit          sq_now  = 0;
        int          wait_n  = 0;
        logic [31:0] tgt     = '0;
        bit          fresh   = 1;
        bit          err     = 0;
        int          errc_m  = 0;
        logic [15:0] recv_m  = '0;
        for (int c = 0; c < ncyc; c++) begin
            int   phase;
            int   p_push;
            int   p_val;
            bit   m_rdy;
            bit   fire;
            bit   fail;
            int   qs0;
            ent_t h;
            ent_t e;
            rec_t r;
            phase = (c / 250) % 4;
            p_push = (phase == 0) ? 50 : (phase == 1) ? 90 : (phase == 2) ? 30 : 70;
            p_val  = (phase == 0) ? 50 : (phase == 1) ? 15 : (phase == 2) ? 80 : 90;
            @(posedge clk);
            #1;
            m_rdy = !sq_now && (wait_n == 0);
            rst[k]        = (c < 1) || ($urandom_range(0, 199) == 0);
            exp_val[k]    = ($urandom_range(0, 99) < p_push);
            exp_pc[k]     = $urandom & 32'hFFFF_FFFC;
            exp_inst[k]   = $urandom;
            exp_squash[k] = ($urandom_range(0, 4) == 0);
            exp_target[k] = $urandom & 32'hFFFF_FFFC;
            val[k]        = ($urandom_range(0, 99) < p_val);
            if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
                pc[k]   = q[0].pc;
                inst[k] = q[0].inst;
                if ($urandom_range(0, 9) == 0) begin
                    if ($urandom_range(0, 1) == 0) pc[k]   = pc[k] ^ (32'h1 << $urandom_range(0, 31));
                    else                           inst[k] = inst[k] ^ (32'h1 << $urandom_range(0, 31));
                end
            end else begin
                pc[k]   = $urandom;
                inst[k] = $urandom;
            end
            if (c > 0) begin
                r.k = k;      r.rdy = m_rdy;  r.sq = sq_now;
                r.erdy = (q.size() < depth);
                r.done = (q.size() == 0) && m_rdy;
                r.err = err;  r.errc = 16'(errc_m); r.recvc = recv_m;
                r.chk_bt = sq_now || fresh;   r.bt = tgt;
                sb.push_back(r);
            end
            if (rst[k]) begin
                q.delete();
                sq_now = 0; wait_n = 0; tgt = '0; fresh = 1;
                err = 0; errc_m = 0; recv_m = '0;
            end else begin
                qs0  = q.size();
                fire = val[k] && m_rdy;
                if (fire) begin
                    recv_m = recv_m + 16'd1;
                    if (qs0 == 0) begin
                        fail = 1;
                    end else begin
                        h = q.pop_front();
                        fail = (h.pc != pc[k]) || (h.inst != inst[k]);
                        if (h.sq) begin
                            sq_now = 1; tgt = h.tgt; fresh = 0;
                        end
                    end
                    wait_n = dly;
                    if (fail) begin
                        err = 1;
                        if (errc_m < 65535) errc_m++;
                    end
                end else if (sq_now) begin
                    sq_now = 0;
                end else if (wait_n > 0) begin
                    wait_n--;
                end
                if (exp_val[k] && qs0 < depth) begin
                    e.pc = exp_pc[k]; e.inst = exp_inst[k]; e.sq = exp_squash[k]; e.tgt = exp_target[k];
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        rst[k] = 1; val[k] = 0; exp_val[k] = 0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; val[i] = 0; exp_val[i] = 0; exp_squash[i] = 0;
            pc[i] = '0; inst[i] = '0; exp_pc[i] = '0; exp_inst[i] = '0; exp_target[i] = '0;
        end
        repeat (2) @(posedge clk);
        run(0, 3000);
        run(1, 3000);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
